fp_addsub_unit: RTL and testbench
=================================

Name: fp_addsub_unit

Overview:
- Parametrised, multi-cycle IEEE-754 add/subtract unit; next generation of the single-precision FPU adder.
- Generalised over exponent and mantissa widths, so one block covers half, single and double precision.
- Adds a subtract opcode, four IEEE rounding modes, full exception flags, and valid/ready handshakes on both sides.
- Sits in the FPU datapath behind the operand register file; the result feeds writeback.

Parameters:
- EXP_W, 8, exponent field width (>=4).
- MAN_W, 23, stored fraction width (>=4); word width W = 1+EXP_W+MAN_W.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  unit can accept; high only in IDLE
- a  input  W  operand A
- b  input  W  operand B
- op_sub  input  1  1: compute a-b; 0: compute a+b
- rnd_mode  input  2  00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  W  packed IEEE result
- flags  output  4  [3] invalid, [2] overflow, [1] underflow, [0] inexact

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, flags=0; in_ready=1 from the first edge with rst high. in_valid is ignored while rst=1.
- Reset mid-operation aborts the operation, discards it, and drops out_valid at that edge.
- Accept: on an edge where in_valid && in_ready, the block registers a, b, op_sub and rnd_mode. Later input changes have no effect.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE; one cycle per state except DONE.
- Fixed latency: out_valid rises 5 edges after the accept edge. No early exit for special operands; specials carry through the states.
- DONE: out_valid=1. result and flags stay stable until the edge where out_ready=1, then the FSM goes to IDLE. in_ready rises the following cycle, so there is no same-cycle turnaround.
- Effective sign of B = b.sign ^ op_sub.
- Larger operand: larger {exp,frac} unsigned compare; on a tie, A is the larger operand.
- ALIGN: smaller significand extended with guard/round/sticky bits. Right-shift amount saturates at MAN_W+3; sticky = OR of all bits shifted out.
- ADD: MAN_W+5 bit add or subtract, according to effective signs.
- NORM:
  - Carry-out: shift right 1, OR the dropped bit into sticky, exp+1.
  - Otherwise: leading-zero count, left shift, exp-lzc.
- ROUND:
  - RNE: increment if G && (R|S|lsb).
  - RTZ: never increment.
  - RDN: increment if negative and any of G/R/S set.
  - RUP: increment if positive and any of G/R/S set.
  - Significand overflow after rounding: exp+1, fraction 0.
  - inexact = G|R|S before rounding.
- Overflow (biased exp >= all-ones):
  - RNE: signed inf.
  - RTZ: max finite.
  - RDN: -inf if negative, else +max finite.
  - RUP: +inf if positive, else -max finite.
  - Sets overflow=1 and inexact=1.
- Exact zero from opposite signs: +0, except -0 under RDN.
- Same-sign zeros: zero of that sign.
- Specials:
  - Any NaN operand -> canonical qNaN {0, all-ones, 1, 0...}. invalid=1 only if an operand is sNaN (fraction MSB=0).
  - inf + (-inf) effective -> qNaN, invalid=1.
  - inf with finite -> that inf, flags 0.
  - Same-sign infs -> that inf.

Optional Feature:
FP_ADDSUB_SUBNORMAL_EN.
- Defined:
  - Subnormal inputs use hidden bit 0 and effective exponent 1.
  - Results below the minimum normal are denormalised before rounding and packed with exp 0.
  - underflow=1 when the result is tiny and inexact.
- Undefined:
  - Subnormal inputs are treated as signed zero (DAZ).
  - Tiny results flush to signed zero with underflow=1 and inexact=1.

Test Plan:
- 3F800000+3F800000, RNE, out_ready held 0 for 3 cycles -> out_valid 5 edges after accept; result 40000000 held stable; flags 0; in_ready 0 until the cycle after the handshake.
- 3F800000 minus 3F800000 (op_sub=1): RNE -> 00000000; RDN -> 80000000; flags 0. Assert rst during ALIGN -> out_valid stays 0 and in_ready=1 next cycle.
- 3F800000+33800000 (tie): RNE -> 3F800000, flags 0001; RUP -> 3F800001, flags 0001; RTZ -> 3F800000, flags 0001.
- 7F7FFFFF+7F7FFFFF: RNE -> 7F800000, flags 0101; RTZ -> 7F7FFFFF, flags 0101; negate both operands with RUP -> FF7FFFFF.
- 7F800000+FF800000 -> 7FC00000, flags 1000; 7F800000+3F800000 -> 7F800000, flags 0000; 7F800001+3F800000 -> 7FC00000, flags 1000.
- 00400000+00400000: with macro -> 00800000, flags 0; without macro -> 00000000, flags 0. 00800000 minus 00800001 (op_sub=1): with macro -> 80000001, flags 0; without macro -> 80000000, flags 0011.

Source files
------------

// File: rtl/fp_addsub_unit_if.sv
// fp_addsub_unit_if: operand request and result handshake bundle for the add/subtract unit
interface fp_addsub_unit_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [1:0] rnd_mode;
  logic [3:0] flags;
  modport master (output in_valid, a, b, op_sub, rnd_mode, out_ready, input in_ready, out_valid, result, flags);
  modport slave (input in_valid, a, b, op_sub, rnd_mode, out_ready, output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp_addsub_unit.sv
// fp_addsub_unit: multi-cycle IEEE-754 add/sub; define FP_ADDSUB_SUBNORMAL_EN for subnormal support (else DAZ/FTZ)
module fp_addsub_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst,
  fp_addsub_unit_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int XW = EXP_W + $clog2(MAN_W + 5) + 1;
  localparam logic [XW-1:0] EMAX = (XW'(1) << EXP_W) - XW'(1);
  localparam logic [XW-1:0] SH_MAX = XW'(MAN_W + 3);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state;
  logic [W-1:0] a_r, b_r, res_r, spec_res, spec_res_c, res_c;
  logic sub_r, valid_r, sl_r, eff_sub, spec_r, zero_r, tiny_r;
  logic [1:0] rm_r;
  logic [3:0] fl_r, spec_fl, spec_fl_c, fl_c;
  logic [XW-1:0] el_r, en_r, xa, xb, sh, lzc, shl, en_c, er;
  logic [SW-1:0] ml_r, ms_r, mn_r, ext_s, sft, mn_c;
  logic [SW:0] sum_r;
  logic [MAN_W+1:0] rs;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic sa, sb, nan_a, nan_b, inf_a, inf_b, snan, swap, carry, tiny_c;
  logic grs, inc, ovf, ovf_inf, hid, flush, uf;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = valid_r;
  assign bus.result = res_r;
  assign bus.flags = fl_r;
  // unpack operands, pick the larger magnitude and align the smaller one with sticky collection
  always_comb begin
    sa = a_r[W-1];
    sb = b_r[W-1] ^ sub_r;
    ea = a_r[W-2:MAN_W];
    eb = b_r[W-2:MAN_W];
`ifdef FP_ADDSUB_SUBNORMAL_EN
    fa = a_r[MAN_W-1:0];
    fb = b_r[MAN_W-1:0];
`else
    fa = ea == '0 ? '0 : a_r[MAN_W-1:0];
    fb = eb == '0 ? '0 : b_r[MAN_W-1:0];
`endif
    nan_a = &ea && |fa;
    nan_b = &eb && |fb;
    inf_a = &ea && ~|fa;
    inf_b = &eb && ~|fb;
    snan = (nan_a && !fa[MAN_W-1]) || (nan_b && !fb[MAN_W-1]);
    xa = ea == '0 ? XW'(1) : XW'(ea);
    xb = eb == '0 ? XW'(1) : XW'(eb);
    swap = {eb, fb} > {ea, fa};
    ext_s = swap ? {ea != '0, fa, 3'b000} : {eb != '0, fb, 3'b000};
    sh = swap ? xb - xa : xa - xb;
    sh = sh > SH_MAX ? SH_MAX : sh;
    sft = ext_s >> sh;
    spec_res_c = (nan_a || nan_b || (inf_a && inf_b && (sa ^ sb))) ? QNAN : inf_a ? {sa, a_r[W-2:0]} : {sb, b_r[W-2:0]};
    spec_fl_c = {snan || (inf_a && inf_b && (sa ^ sb)), 3'b000};
  end
  // leading-zero count and normalisation shift, clamped at the minimum exponent when subnormals exist
  always_comb begin
    lzc = XW'(SW);
    for (int i = 0; i < SW; i++) if (sum_r[i]) lzc = XW'(SW - 1 - i);
    carry = sum_r[SW];
`ifdef FP_ADDSUB_SUBNORMAL_EN
    shl = lzc >= el_r ? el_r - XW'(1) : lzc;
`else
    shl = lzc;
`endif
    tiny_c = !carry && lzc >= el_r;
    mn_c = carry ? {sum_r[SW:2], |sum_r[1:0]} : sum_r[SW-1:0] << shl;
    en_c = carry ? el_r + XW'(1) : el_r - shl;
  end
  // rounding, overflow saturation and final packing with special/zero/flush priority
  always_comb begin
    grs = |mn_r[2:0];
    inc = rm_r == 2'd0 ? mn_r[2] & (mn_r[1] | mn_r[0] | mn_r[3]) : rm_r == 2'd2 ? sl_r & grs : rm_r == 2'd3 ? !sl_r & grs : 1'b0;
    rs = {1'b0, mn_r[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    er = rs[MAN_W+1] ? en_r + XW'(1) : en_r;
    ovf = er >= EMAX;
    ovf_inf = rm_r == 2'd0 || (rm_r == 2'd2 && sl_r) || (rm_r == 2'd3 && !sl_r);
    hid = |rs[MAN_W+1:MAN_W];
`ifdef FP_ADDSUB_SUBNORMAL_EN
    flush = 1'b0;
    uf = tiny_r & grs;
`else
    flush = tiny_r;
    uf = 1'b0;
`endif
    res_c = spec_r ? spec_res : zero_r ? {eff_sub ? rm_r == 2'd2 : sl_r, {(W-1){1'b0}}} : flush ? {sl_r, {(W-1){1'b0}}} : ovf ? (ovf_inf ? {sl_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sl_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}) : {sl_r, hid ? er[EXP_W-1:0] : {EXP_W{1'b0}}, rs[MAN_W-1:0]};
    fl_c = spec_r ? spec_fl : zero_r ? 4'b0000 : flush ? 4'b0011 : {1'b0, ovf, uf, grs | ovf};
  end
  // state sequencing; each state registers its stage result for the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid_r <= 1'b0;
      res_r <= '0;
      fl_r <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r <= bus.a;
          b_r <= bus.b;
          sub_r <= bus.op_sub;
          rm_r <= bus.rnd_mode;
          state <= ALIGN;
        end
        ALIGN: begin
          sl_r <= swap ? sb : sa;
          eff_sub <= sa ^ sb;
          el_r <= swap ? xb : xa;
          ml_r <= swap ? {eb != '0, fb, 3'b000} : {ea != '0, fa, 3'b000};
          ms_r <= {sft[SW-1:1], sft[0] | (|(ext_s & ~({SW{1'b1}} << sh)))};
          spec_r <= nan_a || nan_b || inf_a || inf_b;
          spec_res <= spec_res_c;
          spec_fl <= spec_fl_c;
          state <= ADD;
        end
        ADD: begin
          sum_r <= eff_sub ? {1'b0, ml_r} - {1'b0, ms_r} : {1'b0, ml_r} + {1'b0, ms_r};
          state <= NORM;
        end
        NORM: begin
          mn_r <= mn_c;
          en_r <= en_c;
          zero_r <= ~|sum_r;
          tiny_r <= tiny_c;
          state <= ROUND;
        end
        ROUND: begin
          res_r <= res_c;
          fl_r <= fl_c;
          state <= DONE;
        end
        DONE: if (!valid_r) valid_r <= 1'b1;
        else if (bus.out_ready) begin
          valid_r <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_unit.sv
// tb_fp_addsub_unit: directed self-checking bench for fp_addsub_unit in single precision
module tb_fp_addsub_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  fp_addsub_unit_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fp_addsub_unit #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic xact(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic [1:0] trm,
                      output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    bus.a = ta;
    bus.b = tb;
    bus.op_sub = ts;
    bus.rnd_mode = trm;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = bus.result;
    f = bus.flags;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.a = 32'h3F800000;
    bus.b = 32'h3F800000;
    bus.op_sub = 1'b0;
    bus.rnd_mode = 2'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs out_valid=%b result=%h flags=%b expected 0 00000000 0000", bus.out_valid, bus.result, bus.flags);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_in_valid in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_handshake();
    int lat;
    logic [31:0] r;
    @(negedge clk);
    bus.a = 32'h3F800000;
    bus.b = 32'h3F800000;
    bus.op_sub = 1'b0;
    bus.rnd_mode = 2'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 32'hDEADBEEF;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_ready got %b expected 0", bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL latency got %0d edges expected 5", lat);
    end
    r = bus.result;
    checks++;
    if (r !== 32'h40000000 || bus.flags !== 4'h0) begin
      errors++;
      $display("FAIL one_plus_one result=%h flags=%b expected 40000000 0000", r, bus.flags);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h40000000 || bus.flags !== 4'h0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] out_valid=%b result=%h flags=%b in_ready=%b expected 1 40000000 0000 0", i, bus.out_valid, bus.result, bus.flags, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    int seen;
    xact(32'h3F800000, 32'h3F800000, 1'b1, 2'd0, r, f, lat);
    checks++;
    if (r !== 32'h00000000 || f !== 4'h0 || lat != 5) begin
      errors++;
      $display("FAIL cancel_rne result=%h flags=%b lat=%0d expected 00000000 0000 5", r, f, lat);
    end
    xact(32'h3F800000, 32'h3F800000, 1'b1, 2'd2, r, f, lat);
    checks++;
    if (r !== 32'h80000000 || f !== 4'h0 || lat != 5) begin
      errors++;
      $display("FAIL cancel_rdn result=%h flags=%b lat=%0d expected 80000000 0000 5", r, f, lat);
    end
    @(negedge clk);
    bus.a = 32'h3F800000;
    bus.b = 32'h3F800000;
    bus.op_sub = 1'b0;
    bus.rnd_mode = 2'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_discarded out_valid high for %0d cycles expected 0", seen);
    end
    xact(32'h3F800000, 32'h3F800000, 1'b0, 2'd0, r, f, lat);
    checks++;
    if (r !== 32'h40000000 || f !== 4'h0 || lat != 5) begin
      errors++;
      $display("FAIL after_abort result=%h flags=%b lat=%0d expected 40000000 0000 5", r, f, lat);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    logic [1:0] vm [3];
    logic [31:0] vr [3];
    vm = '{2'd0, 2'd3, 2'd1};
    vr = '{32'h3F800000, 32'h3F800001, 32'h3F800000};
    for (int i = 0; i < 3; i++) begin
      xact(32'h3F800000, 32'h33800000, 1'b0, vm[i], r, f, lat);
      checks++;
      if (r !== vr[i] || f !== 4'b0001 || lat != 5) begin
        errors++;
        $display("FAIL round_tie[%0d] result=%h flags=%b lat=%0d expected %h 0001 5", i, r, f, lat, vr[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    logic [31:0] va [3];
    logic [1:0] vm [3];
    logic [31:0] vr [3];
    va = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF};
    vm = '{2'd0, 2'd1, 2'd3};
    vr = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF};
    for (int i = 0; i < 3; i++) begin
      xact(va[i], va[i], 1'b0, vm[i], r, f, lat);
      checks++;
      if (r !== vr[i] || f !== 4'b0101 || lat != 5) begin
        errors++;
        $display("FAIL overflow[%0d] result=%h flags=%b lat=%0d expected %h 0101 5", i, r, f, lat, vr[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vr [3];
    logic [3:0] vf [3];
    va = '{32'h7F800000, 32'h7F800000, 32'h7F800001};
    vb = '{32'hFF800000, 32'h3F800000, 32'h3F800000};
    vr = '{32'h7FC00000, 32'h7F800000, 32'h7FC00000};
    vf = '{4'b1000, 4'b0000, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      xact(va[i], vb[i], 1'b0, 2'd0, r, f, lat);
      checks++;
      if (r !== vr[i] || f !== vf[i] || lat != 5) begin
        errors++;
        $display("FAIL special[%0d] result=%h flags=%b lat=%0d expected %h %b 5", i, r, f, lat, vr[i], vf[i]);
      end
    end
  endtask

  task automatic test_subnormal();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    logic [31:0] va [2];
    logic [31:0] vb [2];
    logic vs [2];
    logic [31:0] vr [2];
    logic [3:0] vf [2];
    va = '{32'h00400000, 32'h00800000};
    vb = '{32'h00400000, 32'h00800001};
    vs = '{1'b0, 1'b1};
`ifdef FP_ADDSUB_SUBNORMAL_EN
    vr = '{32'h00800000, 32'h80000001};
    vf = '{4'b0000, 4'b0000};
`else
    vr = '{32'h00000000, 32'h80000000};
    vf = '{4'b0000, 4'b0011};
`endif
    for (int i = 0; i < 2; i++) begin
      xact(va[i], vb[i], vs[i], 2'd0, r, f, lat);
      checks++;
      if (r !== vr[i] || f !== vf[i] || lat != 5) begin
        errors++;
        $display("FAIL subnormal[%0d] result=%h flags=%b lat=%0d expected %h %b 5", i, r, f, lat, vr[i], vf[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_cancel();
    test_rounding();
    test_overflow();
    test_specials();
    test_subnormal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
